// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider with signed/unsigned modes and annul
//
// Purpose:
//    Divides opdata1_i by opdata2_i over DIV_W+1 clock edges using a
//    restoring shift-subtract loop. The result is {remainder, quotient}.
//    In signed mode both operands become magnitudes when the operation
//    starts, and the signs are put back onto the final result.
//
// Ports:
//    clk           clock, rising edge
//    rst           asynchronous active-low reset
//    signed_div_i  1 = two's complement divide, 0 = unsigned (sampled with start)
//    opdata1_i     dividend (sampled with start)
//    opdata2_i     divisor  (sampled with start)
//    start_i       request, held high until ready_o is seen
//    annul_i       abort the operation in flight
//    result_o      {remainder, quotient}, valid while ready_o is high
//    ready_o       result_o is valid (registered)

module div #(
   parameter int DIV_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 signed_div_i,
   input  logic [DIV_W-1:0]     opdata1_i,
   input  logic [DIV_W-1:0]     opdata2_i,
   input  logic                 start_i,
   input  logic                 annul_i,
   output logic [2*DIV_W-1:0]   result_o,
   output logic                 ready_o
);

   localparam int CNT_W = $clog2(DIV_W) + 1;

   typedef enum logic [1:0] {
      FREE = 2'd0,
      DBZ  = 2'd1,
      ON   = 2'd2,
      END  = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;

   logic [CNT_W-1:0]     cnt;
   // Partial remainder lives in the upper bits, unconsumed dividend bits and
   // freshly generated quotient bits share the lower DIV_W bits.
   logic [2*DIV_W:0]     work;
   logic [DIV_W-1:0]     divisor_r;
   logic                 neg_quo_r;
   logic                 neg_rem_r;

   // Control decoded from the FSM
   logic                 accept;
   logic                 do_step;
   logic                 finish;
   logic                 dbz_done;
   logic                 clear;

   // Operand magnitudes taken at the start edge
   logic [DIV_W-1:0]     op1_mag;
   logic [DIV_W-1:0]     op2_mag;

   // One restoring step
   logic [DIV_W+1:0]     step_diff;
   logic [2*DIV_W:0]     work_step;

   // Final sign fix-up
   logic [DIV_W-1:0]     quo_raw;
   logic [DIV_W-1:0]     rem_raw;
   logic [DIV_W-1:0]     quo_fix;
   logic [DIV_W-1:0]     rem_fix;

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FREE;
      end else begin
         state <= state_nxt;
      end
   end

   //------------------------------------------------------------------
   // Next-state and control decode
   //------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      do_step   = 1'b0;
      finish    = 1'b0;
      dbz_done  = 1'b0;
      clear     = 1'b0;

      case (state)
         FREE: begin
            // annul_i together with start_i keeps the block idle
            if (start_i && !annul_i) begin
               accept    = 1'b1;
               state_nxt = (opdata2_i == '0) ? DBZ : ON;
            end
         end

         DBZ: begin
            if (annul_i) begin
               clear     = 1'b1;
               state_nxt = FREE;
            end else begin
               dbz_done  = 1'b1;
               state_nxt = END;
            end
         end

         ON: begin
            // Annul wins over completion on the same edge
            if (annul_i) begin
               clear     = 1'b1;
               state_nxt = FREE;
            end else if (cnt == CNT_W'(DIV_W)) begin
               finish    = 1'b1;
               state_nxt = END;
            end else begin
               do_step   = 1'b1;
            end
         end

         END: begin
            if (annul_i || !start_i) begin
               clear     = 1'b1;
               state_nxt = FREE;
            end
         end

         default: begin
            clear     = 1'b1;
            state_nxt = FREE;
         end
      endcase
   end

   //------------------------------------------------------------------
   // Operand conditioning
   //------------------------------------------------------------------
   always_comb begin
      op1_mag = opdata1_i;
      op2_mag = opdata2_i;
      if (signed_div_i && opdata1_i[DIV_W-1]) begin
         op1_mag = {DIV_W{1'b0}} - opdata1_i;
      end
      if (signed_div_i && opdata2_i[DIV_W-1]) begin
         op2_mag = {DIV_W{1'b0}} - opdata2_i;
      end
   end

   //------------------------------------------------------------------
   // Restoring step: shift the whole register left by one, then try to
   // subtract the divisor from the upper part. The subtraction is done
   // one bit wider than the partial remainder so its top bit is a clean
   // borrow flag. On success the new quotient bit (1) drops in at bit 0,
   // otherwise the shifted value is kept and bit 0 stays 0.
   //------------------------------------------------------------------
   always_comb begin
      step_diff = work[2*DIV_W:DIV_W-1] - {2'b00, divisor_r};
      if (step_diff[DIV_W+1]) begin
         work_step = {work[2*DIV_W-1:0], 1'b0};
      end else begin
         work_step = {step_diff[DIV_W:0], work[DIV_W-2:0], 1'b1};
      end
   end

   //------------------------------------------------------------------
   // Result sign fix-up. The most negative dividend over -1 wraps back
   // onto itself through the two negations, which is the intended value.
   //------------------------------------------------------------------
   always_comb begin
      quo_raw = work[DIV_W-1:0];
      rem_raw = work[2*DIV_W-1:DIV_W];
      quo_fix = neg_quo_r ? ({DIV_W{1'b0}} - quo_raw) : quo_raw;
      rem_fix = neg_rem_r ? ({DIV_W{1'b0}} - rem_raw) : rem_raw;
   end

   //------------------------------------------------------------------
   // Datapath and output registers
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         work      <= '0;
         divisor_r <= '0;
         neg_quo_r <= 1'b0;
         neg_rem_r <= 1'b0;
         result_o  <= '0;
         ready_o   <= 1'b0;
      end else begin
         if (accept) begin
            cnt       <= '0;
            work      <= {{(DIV_W+1){1'b0}}, op1_mag};
            divisor_r <= op2_mag;
            neg_quo_r <= signed_div_i & (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
            neg_rem_r <= signed_div_i & opdata1_i[DIV_W-1];
         end else if (do_step) begin
            cnt       <= cnt + CNT_W'(1);
            work      <= work_step;
         end

         if (finish) begin
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
         end else if (dbz_done) begin
            result_o <= '0;
            ready_o  <= 1'b1;
         end else if (clear) begin
            result_o <= '0;
            ready_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard testbench for the multi-cycle divider

module tb_div;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        signed_div_i = 1'b0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [63:0] result_o;
   logic        ready_o;

   div #(.DIV_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] res;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   edge_cnt = 0;
   int   start_edge = 0;
   logic ready_prev = 1'b0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // Reference: plain 64-bit integer division, truncating toward zero
   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint x, y, q, r;
      logic [63:0] qq, rr;
      if (b == 32'h0) return 64'h0;
      if (sgn) begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end else begin
         x = longint'({32'h0, a});
         y = longint'({32'h0, b});
      end
      q = x / y;
      r = x % y;
      qq = q;
      rr = r;
      return {rr[31:0], qq[31:0]};
   endfunction

   // Monitor: on each rising ready_o, compare against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (ready_o && !ready_prev) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ready actual=%h expected=no_result", result_o);
         end else begin
            e   = sb_q.pop_front();
            lat = edge_cnt - start_edge;
            chk("result", result_o, e.res);
            chk("latency", 64'(lat), 64'(e.lat));
         end
      end
      ready_prev = ready_o;
   end

   // Issue one operation; called just after a falling edge
   task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int hold);
      bit got;
      exp_t e;
      e.res = expv;
      e.lat = (b == 32'h0) ? 1 : 33;
      signed_div_i = sgn;
      opdata1_i    = a;
      opdata2_i    = b;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      start_edge   = edge_cnt + 1;
      sb_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (i == 0) begin
            // operands must be ignored once sampled
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = ~sgn;
         end
         if (ready_o) got = 1'b1;
      end
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout actual=0 expected=1 a=%h b=%h", a, b);
         if (sb_q.size() > 0) void'(sb_q.pop_back());
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_ready", 64'(ready_o), 64'd1);
         chk("hold_result", result_o, expv);
      end
      start_i = 1'b0;
      @(negedge clk);
      chk("drop_ready", 64'(ready_o), 64'd0);
      chk("drop_result", result_o, 64'd0);
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (ready_o) seen = 1'b1;
      end
      chk(name, 64'(seen), 64'd0);
   endtask

   initial begin
      bit got;
      exp_t e;
      logic [31:0] a, b;
      bit sgn;

      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      rst = 1'b1;

      // first edge after reset release samples start
      run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
      run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 0);
      run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1);
      run_op(1'b0, 32'h00001234, 32'h0, 64'h0, 5);
      run_op(1'b1, 32'h80000000, 32'h0, 64'h0, 0);
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 0);
      run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 0);
      run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 64'h00000001_00000001, 0);
      run_op(1'b0, 32'h80000000, 32'hC0000000, 64'h80000000_00000000, 0);
      run_op(1'b1, 32'h80000000, 32'h00000001, 64'h00000000_80000000, 0);

      // annul at the 10th ON edge
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      @(negedge clk);
      chk("annul_ready", 64'(ready_o), 64'd0);
      expect_quiet("annul_start_idle", 3);
      start_i = 1'b0;
      annul_i = 1'b0;
      expect_quiet("annul_quiet", 40);
      run_op(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);

      // asynchronous reset at the 20th ON edge
      opdata1_i = 32'd1000;
      opdata2_i = 32'd3;
      start_i   = 1'b1;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_on_ready", 64'(ready_o), 64'd0);
      chk("rst_on_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      opdata1_i = 32'd55;
      opdata2_i = 32'd5;
      expect_quiet("rst_on_quiet", 40);

      // asynchronous reset while a result is held
      signed_div_i = 1'b0;
      opdata1_i    = 32'd99;
      opdata2_i    = 32'd10;
      start_i      = 1'b1;
      start_edge   = edge_cnt + 1;
      e.res = 64'h00000009_00000009;
      e.lat = 33;
      sb_q.push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (ready_o) got = 1'b1;
      end
      chk("end_reached", 64'(got), 64'd1);
      if (!got && sb_q.size() > 0) void'(sb_q.pop_back());
      #2 rst = 1'b0;
      #1;
      chk("rst_end_ready", 64'(ready_o), 64'd0);
      chk("rst_end_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      expect_quiet("rst_end_quiet", 10);

      // randomized operations
      for (int n = 0; n < 60; n++) begin
         sgn = 1'($urandom % 2);
         a   = $urandom;
         case ($urandom % 8)
            0:       b = 32'h0;
            1:       b = $urandom % 16;
            2:       b = 32'hFFFFFFFF;
            3:       a = 32'h80000000 | ($urandom % 4);
            default: b = $urandom >> ($urandom % 32);
         endcase
         if (($urandom % 8) == 3) b = $urandom;
         run_op(sgn, a, b, model(sgn, a, b), int'($urandom % 3));
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter DIV_W, default 32, operand width; only 32 is verified.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 signed_div_i  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start.
REQ-005 opdata1_i  in  DIV_W  dividend; sampled with start.
REQ-006 opdata2_i  in  DIV_W  divisor; sampled with start.
REQ-007 start_i  in  1  request; held high by EX until ready_o is seen, then dropped.
REQ-008 annul_i  in  1  abort the operation in flight (pipeline flush).
REQ-009 result_o  out  2*DIV_W  {remainder, quotient}; upper half goes to HI, lower half to LO.
REQ-010 ready_o  out  1  result_o is valid (registered).

Function
REQ-011 The FSM SHALL have the states FREE, DBZ (divide by zero), ON and END.
REQ-012 FREE: start_i=1 and annul_i=0 at edge E0 SHALL latch signed_div_i, opdata1_i and opdata2_i, clear cnt, and go to DBZ if the divisor is 0, else to ON.
REQ-013 Operand changes after E0 SHALL have no effect until the block returns to FREE.
REQ-014 Signed mode SHALL convert both operands to magnitudes at E0; unsigned mode SHALL use them unchanged.
REQ-015 ON SHALL run one restoring shift-subtract step per edge on a (2*DIV_W+1)-bit working register.
- Each step increments cnt (width clog2(DIV_W)+1).
- Edges E1..E32 perform the 32 steps.
REQ-016 At edge E33 (ON with cnt==DIV_W), the block SHALL register result_o, set ready_o=1 and go to END.
- Latency from start sample to ready_o is DIV_W+1 edges.
REQ-017 Signed sign fix-up on the final result:
- quotient is negated iff the dividend and divisor signs differ;
- remainder takes the dividend's sign.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no exception or flag.
REQ-019 DBZ: at the next edge (E1), the block SHALL set result_o to all zeros, set ready_o=1 and go to END.
REQ-020 END: while start_i=1 and annul_i=0, the block SHALL stay in END, holding result_o and ready_o=1.
REQ-021 END: with start_i=0, the next edge SHALL go to FREE, clear ready_o and clear result_o.
REQ-022 annul_i=1 in ON, DBZ or END SHALL go to FREE at the next edge.
- ready_o=0 and result_o=0 after that edge.
- Takes priority over completion on the same edge.
REQ-023 annul_i=1 with start_i=1 in FREE SHALL stay in FREE.
REQ-024 start_i dropping during ON SHALL be ignored; the operation completes.
REQ-025 In FREE, ON and DBZ, ready_o SHALL be 0.
REQ-026 Back-to-back: after END→FREE, a new start SHALL be accepted at the next edge.

Reset
REQ-027 rst=0 SHALL immediately, without waiting for a clock edge, force FREE, cnt=0, working register=0, result_o=0 and ready_o=0.
REQ-028 Reset asserted mid-ON SHALL discard the operation.
- After reset release, ready_o stays 0 until a new start completes.
REQ-029 The first edge after rst rises SHALL be able to sample start_i in FREE.

Verification
REQ-030 Unsigned 100/7 (signed_div_i=0) -> ready_o high exactly 33 edges after the start sample; result_o=0x00000002_0000000E.
REQ-031 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7/-2 -> 0x00000001_FFFFFFFD.
REQ-032 Divisor 0 (any dividend) -> ready_o high 1 edge after start, result_o=0; start_i held 5 edges -> ready_o stays 1; start_i dropped -> ready_o=0 next edge.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000; unsigned 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
REQ-034 annul_i pulsed at the 10th ON edge -> FREE next edge, ready_o never rises.
- A new 100/7 started afterwards completes normally with the correct result.
REQ-035 rst pulled low at the 20th ON edge (asynchronously, between edges) -> ready_o=0 and result_o=0 with no clock.
- After release, an operand change with start_i=0 produces no activity.
